// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the frame-buffer write port between CPU bypass
// stores (decoupled through a small FIFO), the fill engine and the line engine.
// Grants rotate round-robin into a single registered output slot.
// Optional build macro FB_ARB_STATS_EN adds saturating per-source completion
// counters and a CPU stall-cycle counter.
module fb_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic [3:0]        cpu_we,
    output logic              cpu_stall,
    input  logic              fill_valid,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_din,
    output logic              fill_ready,
    input  logic              line_valid,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [DATA_W-1:0] line_din,
    output logic              line_ready,
    output logic              fb_valid,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din,
    output logic [3:0]        fb_we,
    input  logic              fb_ready,
    output logic [1:0]        fb_grant,
    output logic              idle
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu,
    output logic [31:0]       stat_fill,
    output logic [31:0]       stat_line,
    output logic [31:0]       stat_stall_cycles
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_din  [FIFO_DEPTH];
    logic [3:0]        r_mem_we   [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_last;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_load;
    logic       w_go;
    logic [2:0] w_req;
    logic [1:0] w_win;
    logic       w_win_valid;

    // Index of the requester 'step' positions after 'base' in the cycle 0->1->2.
    function automatic logic [1:0] next_idx(input logic [1:0] base, input int step);
        int s;
        s = (int'(base) + step) % 3;
        return 2'(s);
    endfunction

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cpu_valid && !w_full;
    assign cpu_stall = cpu_valid && w_full;
    assign w_req     = {line_valid, fill_valid, !w_empty};
    assign w_load    = !fb_valid || fb_ready;
    assign w_go      = w_load && w_win_valid;
    assign w_pop     = w_go && (w_win == 2'd0);
    assign fill_ready = w_go && (w_win == 2'd1);
    assign line_ready = w_go && (w_win == 2'd2);
    assign idle      = w_empty && !fb_valid;

    // Round-robin pick: scan farthest-to-nearest so the nearest requester after r_last wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_win       = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (w_req[next_idx(r_last, k)]) begin
                w_win_valid = 1'b1;
                w_win       = next_idx(r_last, k);
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= cpu_addr;
            r_mem_din[r_wr_ptr]  <= cpu_din;
            r_mem_we[r_wr_ptr]   <= cpu_we;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output slot: loads the winner when free or being accepted, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_valid <= 1'b0;
            fb_addr  <= '0;
            fb_din   <= '0;
            fb_we    <= '0;
            fb_grant <= 2'd0;
            r_last   <= 2'd2;
        end else if (w_load) begin
            if (w_win_valid) begin
                fb_valid <= 1'b1;
                fb_grant <= w_win;
                r_last   <= w_win;
                case (w_win)
                    2'd0: begin
                        fb_addr <= r_mem_addr[r_rd_ptr];
                        fb_din  <= r_mem_din[r_rd_ptr];
                        fb_we   <= r_mem_we[r_rd_ptr];
                    end
                    2'd1: begin
                        fb_addr <= fill_addr;
                        fb_din  <= fill_din;
                        fb_we   <= 4'b1111;
                    end
                    default: begin
                        fb_addr <= line_addr;
                        fb_din  <= line_din;
                        fb_we   <= 4'b1111;
                    end
                endcase
            end else begin
                fb_valid <= 1'b0;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    // Saturating counters of completed transactions per source and CPU stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cpu          <= '0;
            stat_fill         <= '0;
            stat_line         <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (fb_valid && fb_ready) begin
                if (fb_grant == 2'd0 && stat_cpu  != 32'hFFFF_FFFF) stat_cpu  <= stat_cpu + 32'd1;
                if (fb_grant == 2'd1 && stat_fill != 32'hFFFF_FFFF) stat_fill <= stat_fill + 32'd1;
                if (fb_grant == 2'd2 && stat_line != 32'hFFFF_FFFF) stat_line <= stat_line + 32'd1;
            end
            if (cpu_stall && stat_stall_cycles != 32'hFFFF_FFFF)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_fb_write_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [3:0]    cpu_we;
    logic          cpu_stall;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_din;
    logic          fill_ready;
    logic          line_valid;
    logic [AW-1:0] line_addr;
    logic [DW-1:0] line_din;
    logic          line_ready;
    logic          fb_valid;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_din;
    logic [3:0]    fb_we;
    logic          fb_ready;
    logic [1:0]    fb_grant;
    logic          idle;
`ifdef FB_ARB_STATS_EN
    logic [31:0]   stat_cpu, stat_fill, stat_line, stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    fb_write_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_stall(cpu_stall),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_din(fill_din), .fill_ready(fill_ready),
        .line_valid(line_valid), .line_addr(line_addr), .line_din(line_din), .line_ready(line_ready),
        .fb_valid(fb_valid), .fb_addr(fb_addr), .fb_din(fb_din), .fb_we(fb_we),
        .fb_ready(fb_ready), .fb_grant(fb_grant), .idle(idle)
`ifdef FB_ARB_STATS_EN
        , .stat_cpu(stat_cpu), .stat_fill(stat_fill), .stat_line(stat_line),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    we;
    } store_t;

    // Reference model state
    store_t        mq[$];
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [3:0]    m_we;
    int            m_grant;
    int            m_last;
    int            m_done[3];
    int            m_stall_cyc;

    // Model predictions for the current cycle
    bit e_stall, e_load, e_fill_rdy, e_line_rdy;
    int e_win;

    int n_checks = 0;
    int n_pass   = 0;
    bit last_stall;
    bit rec_en = 1'b0;
    int rec[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_addr = '0; m_din = '0; m_we = '0;
        m_grant = 0;
        m_last = 2;
        m_done = '{0, 0, 0};
        m_stall_cyc = 0;
    endfunction

    function automatic bit model_req(input int j);
        if (j == 0) return mq.size() > 0;
        if (j == 1) return fill_valid;
        return line_valid;
    endfunction

    function automatic void model_eval();
        e_stall = cpu_valid && (mq.size() == DEPTH);
        e_load  = !m_valid || fb_ready;
        e_win   = -1;
        for (int k = 1; k <= 3; k++) begin
            if (e_win < 0 && model_req((m_last + k) % 3)) e_win = (m_last + k) % 3;
        end
        e_fill_rdy = e_load && (e_win == 1);
        e_line_rdy = e_load && (e_win == 2);
    endfunction

    function automatic void model_update();
        store_t st;
        bit push;
        if (rst) begin
            model_reset();
            return;
        end
        push = cpu_valid && !e_stall;
        if (m_valid && fb_ready) m_done[m_grant]++;
        if (e_stall) m_stall_cyc++;
        if (e_load) begin
            if (e_win >= 0) begin
                if (e_win == 0) begin
                    st = mq.pop_front();
                    m_addr = st.a; m_din = st.d; m_we = st.we;
                end else if (e_win == 1) begin
                    m_addr = fill_addr; m_din = fill_din; m_we = 4'hF;
                end else begin
                    m_addr = line_addr; m_din = line_din; m_we = 4'hF;
                end
                m_valid = 1'b1;
                m_grant = e_win;
                m_last  = e_win;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (push) mq.push_back('{cpu_addr, cpu_din, cpu_we});
    endfunction

    // One clock: check settled outputs against the model, clock, advance the model.
    task automatic step();
        #1;
        model_eval();
        chk("fb_valid", fb_valid, m_valid);
        if (m_valid) begin
            chk("fb_addr", fb_addr, m_addr);
            chk("fb_din", fb_din, m_din);
            chk("fb_we", fb_we, m_we);
            chk("fb_grant", fb_grant, m_grant);
        end
        chk("cpu_stall", cpu_stall, e_stall);
        chk("fill_ready", fill_ready, e_fill_rdy);
        chk("line_ready", line_ready, e_line_rdy);
        chk("idle", idle, (mq.size() == 0) && !m_valid);
        last_stall = cpu_stall;
        if (rec_en && fb_valid) rec.push_back(int'(fb_grant));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_cpu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] we);
        cpu_valid = v; cpu_addr = a; cpu_din = d; cpu_we = we;
    endtask

    task automatic drain();
        cpu_valid = 0; fill_valid = 0; line_valid = 0; fb_ready = 1;
        repeat (8) step();
    endtask

    int exp_seq[11] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 1, 2};

    initial begin
        rst = 1; fb_ready = 0;
        drive_cpu(0, '0, '0, '0);
        fill_valid = 0; fill_addr = '0; fill_din = '0;
        line_valid = 0; line_addr = '0; line_din = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        rst = 0;
        #1;
        chk("rst_fb_valid", fb_valid, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_din", fb_din, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_grant", fb_grant, 0);
        chk("rst_idle", idle, 1);
        chk("rst_stall", cpu_stall, 0);

        // Single CPU store
        fb_ready = 1;
        drive_cpu(1, 32'h1000_0040, 32'hDEAD_BEEF, 4'b0011);
        step();
        drive_cpu(0, '0, '0, '0);
        step();
        #1;
        chk("t1_valid", fb_valid, 1);
        chk("t1_addr", fb_addr, 32'h1000_0040);
        chk("t1_din", fb_din, 32'hDEAD_BEEF);
        chk("t1_we", fb_we, 4'b0011);
        chk("t1_grant", fb_grant, 0);
        step();
        #1;
        chk("t1_idle", idle, 1);
        drain();

        // Rotation: one store in the slot, two in the FIFO, fill and line always requesting
        fb_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cpu(1, 32'h2000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
            step();
        end
        drive_cpu(0, '0, '0, '0);
        fill_valid = 1; fill_addr = 32'h3000_0000; fill_din = 32'h1111_1111;
        line_valid = 1; line_addr = 32'h4000_0000; line_din = 32'h2222_2222;
        fb_ready = 1;
        rec.delete();
        rec_en = 1;
        repeat (11) step();
        rec_en = 0;
        chk("t2_len", rec.size(), 11);
        for (int i = 0; i < 11; i++)
            chk("t2_seq", (i < rec.size()) ? rec[i] : -1, exp_seq[i]);
        drain();

        // Backpressure hold with all sources requesting
        fb_ready = 0;
        fill_valid = 1; fill_addr = 32'h5000_0000; fill_din = 32'h3333_3333;
        line_valid = 1;
        drive_cpu(1, 32'h5100_0000, 32'h4444_4444, 4'hC);
        repeat (6) step();
        drive_cpu(0, '0, '0, '0);
        fb_ready = 1;
        repeat (4) step();
        drain();

        // FIFO overflow: slot occupied, five back-to-back stores, fifth stalls
        fb_ready = 0;
        fill_valid = 1;
        step();
        fill_valid = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cpu(1, 32'h6000_0000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF);
            step();
            chk("t4_stall", last_stall, (i == 4));
        end
        repeat (2) step();
        fb_ready = 1;
        for (int n = 0; n < 10 && e_stall; n++) step();
        chk("t4_accepted", e_stall, 0);
        drive_cpu(0, '0, '0, '0);
        repeat (8) step();

        // Reset while busy: slot valid and three stores queued
        fb_ready = 0;
        fill_valid = 1;
        step();
        fill_valid = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cpu(1, 32'h7000_0000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'h5);
            step();
        end
        drive_cpu(0, '0, '0, '0);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("t5_valid", fb_valid, 0);
        chk("t5_idle", idle, 1);
        fb_ready = 1;
        drive_cpu(1, 32'h7100_0000, 32'hD000_0000, 4'h9);
        step();
        drive_cpu(0, '0, '0, '0);
        fill_valid = 1; line_valid = 1;
        step();
        #1;
        chk("t5_first_valid", fb_valid, 1);
        chk("t5_first_grant", fb_grant, 0);
        drain();

        // Randomized traffic; stalled CPU stores are held until accepted
        for (int c = 0; c < 1500; c++) begin
            if (!(cpu_valid && e_stall))
                drive_cpu($urandom_range(0, 99) < 45, $urandom, $urandom, 4'($urandom));
            fill_valid = $urandom_range(0, 99) < 35;
            fill_addr  = $urandom; fill_din = $urandom;
            line_valid = $urandom_range(0, 99) < 35;
            line_addr  = $urandom; line_din = $urandom;
            fb_ready   = $urandom_range(0, 99) < 60;
            rst        = $urandom_range(0, 299) == 0;
            step();
        end
        rst = 0;
        drain();

`ifdef FB_ARB_STATS_EN
        #1;
        chk("stat_cpu", stat_cpu, m_done[0]);
        chk("stat_fill", stat_fill, m_done[1]);
        chk("stat_line", stat_line, m_done[2]);
        chk("stat_stall", stat_stall_cycles, m_stall_cyc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
